pc_source_unit: RTL and testbench

- Parametrised next-PC selection and PC-holding block for the multicycle datapath; generalises the fixed 5-way PC-source mux.
- Selects one of N_SRC next-PC candidates using a binary selector, with out-of-range handling.
- Owns the PC register with unconditional and conditional load, misalignment trapping to an exception vector, and an EPC/cause capture.
- Keeps a saturating count of taken redirects; sits between the control unit and instruction-memory address path.

---
 rtl/pc_source_unit.sv | 133 +++++++++++++
 tb/tb_pc_source_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_source_unit.sv
// pc_source_unit
//   Next-PC selection and PC register for the multicycle datapath.
//   Picks one of N_SRC candidate addresses with a binary selector and
//   loads it into the PC on an unconditional or branch-qualified write.
//   Loads of a misaligned address, and external exception requests, divert
//   the PC to EXC_VEC. The PC of the faulting step is saved in epc_out and
//   the reason in cause. The unit stays in TRAP until the handler
//   acknowledges. It also keeps a saturating count of taken redirects.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   selector       candidate index; candidate k = data_in[k*WIDTH +: WIDTH]
//   data_in        flattened candidates; index 0 is the PC+4 path
//   pc_write       unconditional PC load
//   pc_write_cond  conditional PC load, qualified by cond
//   cond           branch condition
//   exc_req        external exception request
//   exc_ack        handler acknowledge, leaves TRAP
//   pc_out         current PC
//   epc_out        PC captured at trap entry
//   cause          bit0 = external request, bit1 = misaligned target
//   exc_pending    high while in TRAP
//   sel_err        one-cycle pulse after a load with an out-of-range selector
//   redirect_cnt   saturating count of taken loads with selector != 0
module pc_source_unit #(
  parameter int                 WIDTH       = 32,
  parameter int                 N_SRC       = 5,
  parameter int                 SEL_W       = 3,
  parameter logic [WIDTH-1:0]   RESET_VEC   = '0,
  parameter logic [WIDTH-1:0]   EXC_VEC     = WIDTH'(32'h0000_00FC),
  parameter bit                 ALIGN_CHECK = 1'b1,
  parameter int                 CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       selector,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  input  logic                   pc_write,
  input  logic                   pc_write_cond,
  input  logic                   cond,
  input  logic                   exc_req,
  input  logic                   exc_ack,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       epc_out,
  output logic [1:0]             cause,
  output logic                   exc_pending,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       redirect_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t state;

  // Unpacked view of the flattened candidate bus.
  logic [WIDTH-1:0] slices [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slice
    assign slices[gi] = data_in[gi*WIDTH +: WIDTH];
  end

  logic             in_range;
  logic [WIDTH-1:0] next_pc;
  logic             load;
  logic             misalign;
  logic             trap_entry;

  assign in_range = (int'(selector) < N_SRC);

  // Out-of-range selectors fall back to the PC+4 path (slice 0).
  always_comb begin
    next_pc = slices[0];
    for (int k = 1; k < N_SRC; k++) begin
      if (int'(selector) == k) begin
        next_pc = slices[k];
      end
    end
  end

  // pc_write dominates, so both write strobes high acts as an unconditional load.
  assign load       = pc_write | (pc_write_cond & cond);
  assign misalign   = ALIGN_CHECK && load && (next_pc[1:0] != 2'b00);
  assign trap_entry = exc_req | misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      pc_out       <= RESET_VEC;
      epc_out      <= '0;
      cause        <= 2'b00;
      exc_pending  <= 1'b0;
      sel_err      <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          sel_err <= load & ~in_range;
          if (trap_entry) begin
            // Save the PC of the faulting step; the bad target is never loaded.
            epc_out     <= pc_out;
            cause       <= {misalign, exc_req};
            pc_out      <= EXC_VEC;
            exc_pending <= 1'b1;
            state       <= TRAP;
          end else if (load) begin
            pc_out <= next_pc;
            if ((selector != '0) && (redirect_cnt != {CNT_W{1'b1}})) begin
              redirect_cnt <= redirect_cnt + 1'b1;
            end
          end
        end
        TRAP: begin
          // Loads, requests and selector are dropped here, not queued.
          sel_err <= 1'b0;
          if (exc_ack) begin
            exc_pending <= 1'b0;
            state       <= RUN;
          end
        end
        default: begin
          state       <= RUN;
          exc_pending <= 1'b0;
          sel_err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_source_unit.sv
module tb_pc_source_unit;

  localparam int N_SRC = 5;
  localparam logic [31:0] EXC = 32'h0000_00FC;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  selector;
  logic [N_SRC*32-1:0] data_in;
  logic        pc_write, pc_write_cond, cond, exc_req, exc_ack;

  logic [31:0] pc_out, epc_out, pc_out2, epc_out2;
  logic [1:0]  cause, cause2;
  logic        exc_pending, sel_err, exc_pending2, sel_err2;
  logic [15:0] redirect_cnt;
  logic [1:0]  redirect_cnt2;

  logic [31:0] cand [N_SRC];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  logic        m_trap, m_selerr;
  int          m_cnt;

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int k = 0; k < N_SRC; k++) data_in[k*32 +: 32] = cand[k];
  end

  pc_source_unit dut (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .exc_req(exc_req), .exc_ack(exc_ack),
    .pc_out(pc_out), .epc_out(epc_out), .cause(cause),
    .exc_pending(exc_pending), .sel_err(sel_err), .redirect_cnt(redirect_cnt)
  );

  pc_source_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .selector(selector), .data_in(data_in),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond(cond),
    .exc_req(exc_req), .exc_ack(exc_ack),
    .pc_out(pc_out2), .epc_out(epc_out2), .cause(cause2),
    .exc_pending(exc_pending2), .sel_err(sel_err2), .redirect_cnt(redirect_cnt2)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00;
    m_trap = 1'b0; m_selerr = 1'b0; m_cnt = 0;
  endtask

  // One clock of the architectural rules, evaluated on the current inputs.
  task automatic model_step();
    logic        ld, ok, mis;
    logic [31:0] tgt;
    ld  = pc_write | (pc_write_cond & cond);
    ok  = (int'(selector) < N_SRC);
    tgt = ok ? cand[selector] : cand[0];
    if (m_trap) begin
      m_selerr = 1'b0;
      if (exc_ack) m_trap = 1'b0;
    end else begin
      mis      = ld && (tgt[1:0] != 2'b00);
      m_selerr = ld && !ok;
      if (exc_req || mis) begin
        m_epc   = m_pc;
        m_cause = {mis, exc_req};
        m_pc    = EXC;
        m_trap  = 1'b1;
      end else if (ld) begin
        m_pc = tgt;
        if (selector != 3'd0 && m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic idle_inputs();
    selector = 3'd0; pc_write = 1'b0; pc_write_cond = 1'b0;
    cond = 1'b0; exc_req = 1'b0; exc_ack = 1'b0;
  endtask

  // Apply current inputs for one clock; returns 1 ns after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_base_cands();
    cand[0] = 32'h10; cand[1] = 32'h20; cand[2] = 32'h30;
    cand[3] = 32'h40; cand[4] = 32'h50;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    set_base_cands();
    model_reset();
    #12;
    checks++;
    if (pc_out !== 32'h0 || epc_out !== 32'h0 || cause !== 2'b00 ||
        exc_pending !== 1'b0 || sel_err !== 1'b0 || redirect_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: pc=%h epc=%h cause=%b pend=%b selerr=%b cnt=%0d required all zero",
               pc_out, epc_out, cause, exc_pending, sel_err, redirect_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc_out !== 32'h0 || redirect_cnt !== 16'h0 || exc_pending !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: pc=%h cnt=%0d pend=%b required 0/0/0",
                 i, pc_out, redirect_cnt, exc_pending);
      end
    end
    $display("test_reset done: pc=%h", pc_out);
  endtask

  task automatic test_select();
    selector = 3'd2; pc_write = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h30 || redirect_cnt !== 16'd1) begin
      errors++;
      $display("FAIL select2: pc=%h cnt=%0d required 00000030/1", pc_out, redirect_cnt);
    end
    selector = 3'd6;
    step();
    checks++;
    if (pc_out !== 32'h10 || sel_err !== 1'b1 || redirect_cnt !== 16'd2) begin
      errors++;
      $display("FAIL select_out_of_range: pc=%h selerr=%b cnt=%0d required 00000010/1/2",
               pc_out, sel_err, redirect_cnt);
    end
    idle_inputs();
    step();
    checks++;
    if (sel_err !== 1'b0 || pc_out !== 32'h10) begin
      errors++;
      $display("FAIL sel_err_one_cycle: selerr=%b pc=%h required 0/00000010", sel_err, pc_out);
    end
    $display("test_select done: pc=%h cnt=%0d", pc_out, redirect_cnt);
  endtask

  task automatic test_cond();
    pc_write_cond = 1'b1; cond = 1'b0; selector = 3'd1;
    step();
    checks++;
    if (pc_out !== 32'h10) begin
      errors++;
      $display("FAIL cond_false: pc=%h required 00000010", pc_out);
    end
    cond = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h20 || redirect_cnt !== 16'd3) begin
      errors++;
      $display("FAIL cond_true: pc=%h cnt=%0d required 00000020/3", pc_out, redirect_cnt);
    end
    idle_inputs();
    $display("test_cond done: pc=%h", pc_out);
  endtask

  task automatic test_misalign();
    cand[3] = 32'h42;
    pc_write = 1'b1; selector = 3'd3;
    step();
    checks++;
    if (pc_out !== EXC || epc_out !== 32'h20 || cause !== 2'b10 ||
        exc_pending !== 1'b1 || redirect_cnt !== 16'd3) begin
      errors++;
      $display("FAIL misalign_trap: pc=%h epc=%h cause=%b pend=%b cnt=%0d required 000000fc/00000020/10/1/3",
               pc_out, epc_out, cause, exc_pending, redirect_cnt);
    end
    cand[3] = 32'h40;
    step();
    checks++;
    if (pc_out !== EXC || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL load_in_trap: pc=%h pend=%b required 000000fc/1", pc_out, exc_pending);
    end
    pc_write = 1'b0; exc_ack = 1'b1;
    step();
    checks++;
    if (exc_pending !== 1'b0 || cause !== 2'b10 || pc_out !== EXC) begin
      errors++;
      $display("FAIL exc_ack: pend=%b cause=%b pc=%h required 0/10/000000fc", exc_pending, cause, pc_out);
    end
    exc_ack = 1'b0; pc_write = 1'b1; selector = 3'd4;
    step();
    checks++;
    if (pc_out !== 32'h50 || redirect_cnt !== 16'd4) begin
      errors++;
      $display("FAIL load_after_ack: pc=%h cnt=%0d required 00000050/4", pc_out, redirect_cnt);
    end
    idle_inputs();
    $display("test_misalign done: pc=%h", pc_out);
  endtask

  task automatic test_both_causes();
    cand[2] = 32'h31;
    pc_write = 1'b1; selector = 3'd2; exc_req = 1'b1;
    step();
    checks++;
    if (cause !== 2'b11 || epc_out !== 32'h50 || pc_out !== EXC || exc_pending !== 1'b1) begin
      errors++;
      $display("FAIL both_causes: cause=%b epc=%h pc=%h pend=%b required 11/00000050/000000fc/1",
               cause, epc_out, pc_out, exc_pending);
    end
    idle_inputs();
    exc_ack = 1'b1;
    step();
    idle_inputs();
    set_base_cands();
    $display("test_both_causes done: cause=%b", cause);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_SRC; k++) begin
        v = $urandom();
        if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
        cand[k] = v;
      end
      selector      = 3'($urandom_range(0, 7));
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = ($urandom_range(0, 2) == 0);
      cond          = $urandom_range(0, 1) == 1;
      exc_req       = ($urandom_range(0, 15) == 0);
      exc_ack       = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (pc_out !== m_pc || epc_out !== m_epc || cause !== m_cause ||
          exc_pending !== m_trap || sel_err !== m_selerr || redirect_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h/%h epc=%h/%h cause=%b/%b pend=%b/%b selerr=%b/%b cnt=%0d/%0d (got/required)",
                 i, pc_out, m_pc, epc_out, m_epc, cause, m_cause, exc_pending, m_trap,
                 sel_err, m_selerr, redirect_cnt, m_cnt);
      end
      checks++;
      if (pc_out2 !== m_pc || redirect_cnt2 !== 2'((m_cnt > 3) ? 3 : m_cnt)) begin
        errors++;
        $display("FAIL random_narrow[%0d]: pc=%h/%h cnt=%0d/%0d (got/required)",
                 i, pc_out2, m_pc, redirect_cnt2, (m_cnt > 3) ? 3 : m_cnt);
      end
    end
    idle_inputs();
    set_base_cands();
    $display("test_random done: cnt=%0d", m_cnt);
  endtask

  task automatic test_reset_in_trap();
    if (m_trap) begin
      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
    end
    pc_write = 1'b1; selector = 3'd1;
    step();
    pc_write = 1'b0; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    checks++;
    if (exc_pending !== 1'b1 || epc_out !== 32'h20) begin
      errors++;
      $display("FAIL trap_before_reset: pend=%b epc=%h required 1/00000020", exc_pending, epc_out);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pc_out !== 32'h0 || epc_out !== 32'h0 || cause !== 2'b00 ||
        exc_pending !== 1'b0 || redirect_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_in_trap: pc=%h epc=%h cause=%b pend=%b cnt=%0d required all zero",
               pc_out, epc_out, cause, exc_pending, redirect_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    pc_write = 1'b1; selector = 3'd2;
    step();
    checks++;
    if (pc_out !== 32'h30 || exc_pending !== 1'b0) begin
      errors++;
      $display("FAIL run_after_reset: pc=%h pend=%b required 00000030/0", pc_out, exc_pending);
    end
    idle_inputs();
    $display("test_reset_in_trap done: pc=%h", pc_out);
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      pc_write = 1'b1; selector = 3'(1 + (i % 4));
      step();
      checks++;
      if (redirect_cnt2 !== 2'((i > 3) ? 3 : i) || redirect_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL saturation[%0d]: narrow=%0d wide=%0d required %0d/%0d",
                 i, redirect_cnt2, redirect_cnt, (i > 3) ? 3 : i, i);
      end
    end
    idle_inputs();
    $display("test_saturation done: narrow=%0d wide=%0d", redirect_cnt2, redirect_cnt);
  endtask

  initial begin
    test_reset();
    test_select();
    test_cond();
    test_misalign();
    test_both_causes();
    test_random();
    test_reset_in_trap();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
